// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a single shared memory port.
// Each access is IDLE -> ACCESS (LAT cycles) -> DONE, then back to IDLE.
module mem_arbiter #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_last;
  logic        r_id;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_rdata;

  logic w_any;
  logic w_win;
  logic w_access;
  logic w_first;
  logic w_done;

  // On a tie the requester that did not win last time takes the port.
  always_comb begin
    w_any = m0_req | m1_req;
    w_win = (m0_req && m1_req) ? ~r_last : m1_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_last  <= 1'b1;
      r_id    <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= ACCESS;
            r_cnt   <= LAT_M1;
            r_last  <= w_win;
            r_id    <= w_win;
          end
        end
        ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state <= DONE;
            r_rdata <= r_we ? 32'd0 : mem_rdata;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Payload is only ever observed through ACCESS-gated outputs, so it needs no reset.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && w_any) begin
      r_we    <= w_win ? m1_we    : m0_we;
      r_addr  <= w_win ? m1_addr  : m0_addr;
      r_wdata <= w_win ? m1_wdata : m0_wdata;
      r_wstrb <= w_win ? m1_wstrb : m0_wstrb;
    end
  end

  always_comb begin
    w_access  = (r_state == ACCESS);
    w_first   = w_access && (r_cnt == LAT_M1);
    w_done    = (r_state == DONE);
    m0_gnt    = w_first && !r_id;
    m1_gnt    = w_first &&  r_id;
    m0_done   = w_done  && !r_id;
    m1_done   = w_done  &&  r_id;
    m0_rdata  = (w_done && !r_id) ? r_rdata : 32'd0;
    m1_rdata  = (w_done &&  r_id) ? r_rdata : 32'd0;
    mem_read  = w_access && !r_we;
    mem_write = w_access &&  r_we;
    mem_addr  = w_access ? r_addr  : 32'd0;
    mem_wdata = w_access ? r_wdata : 32'd0;
    mem_wstrb = w_access ? r_wstrb : 4'd0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances with LAT = 1, 2, 3 share clk/rst.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m0_req [3], m0_we [3], m1_req [3], m1_we [3];
  logic [31:0] m0_addr [3], m0_wdata [3], m1_addr [3], m1_wdata [3];
  logic [3:0]  m0_wstrb [3], m1_wstrb [3];
  logic        m0_gnt [3], m0_done [3], m1_gnt [3], m1_done [3];
  logic [31:0] m0_rdata [3], m1_rdata [3];
  logic        mem_read [3], mem_write [3];
  logic [31:0] mem_addr [3], mem_wdata [3], mem_rdata [3];
  logic [3:0]  mem_wstrb [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_arbiter #(.LAT(g + 1)) u_dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req[g]), .m0_we(m0_we[g]), .m0_addr(m0_addr[g]),
      .m0_wdata(m0_wdata[g]), .m0_wstrb(m0_wstrb[g]),
      .m0_gnt(m0_gnt[g]), .m0_done(m0_done[g]), .m0_rdata(m0_rdata[g]),
      .m1_req(m1_req[g]), .m1_we(m1_we[g]), .m1_addr(m1_addr[g]),
      .m1_wdata(m1_wdata[g]), .m1_wstrb(m1_wstrb[g]),
      .m1_gnt(m1_gnt[g]), .m1_done(m1_done[g]), .m1_rdata(m1_rdata[g]),
      .mem_read(mem_read[g]), .mem_write(mem_write[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_wstrb(mem_wstrb[g]), .mem_rdata(mem_rdata[g])
    );
  end

  typedef struct {
    int          lat;
    logic        who;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] mdata;
    logic [31:0] exp_rdata;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input int k, input string tag);
    chk({tag, " m0_gnt"},    32'(m0_gnt[k]),    32'd0);
    chk({tag, " m1_gnt"},    32'(m1_gnt[k]),    32'd0);
    chk({tag, " m0_done"},   32'(m0_done[k]),   32'd0);
    chk({tag, " m1_done"},   32'(m1_done[k]),   32'd0);
    chk({tag, " m0_rdata"},  m0_rdata[k],       32'd0);
    chk({tag, " m1_rdata"},  m1_rdata[k],       32'd0);
    chk({tag, " mem_read"},  32'(mem_read[k]),  32'd0);
    chk({tag, " mem_write"}, 32'(mem_write[k]), 32'd0);
    chk({tag, " mem_addr"},  mem_addr[k],       32'd0);
    chk({tag, " mem_wdata"}, mem_wdata[k],      32'd0);
    chk({tag, " mem_wstrb"}, 32'(mem_wstrb[k]), 32'd0);
  endtask

  task automatic drop(input int k);
    m0_req[k] = 1'b0;
    m1_req[k] = 1'b0;
  endtask

  // One isolated access from a single requester; payload is scrambled after
  // the sampling edge so the bench sees whether the arbiter really latched it.
  task automatic run_vec(input int n, input vec_t v);
    int    k;
    string t;
    k = v.lat - 1;
    if (v.who) begin
      m1_req[k] = 1'b1; m1_we[k] = v.we; m1_addr[k] = v.addr;
      m1_wdata[k] = v.wdata; m1_wstrb[k] = v.wstrb;
    end else begin
      m0_req[k] = 1'b1; m0_we[k] = v.we; m0_addr[k] = v.addr;
      m0_wdata[k] = v.wdata; m0_wstrb[k] = v.wstrb;
    end
    mem_rdata[k] = v.mdata;
    tick();
    drop(k);
    m0_we[k] = ~v.we; m1_we[k] = ~v.we;
    m0_addr[k] = 32'hFFFF_FFFF; m1_addr[k] = 32'hFFFF_FFFF;
    m0_wdata[k] = 32'h5A5A_5A5A; m1_wdata[k] = 32'h5A5A_5A5A;
    m0_wstrb[k] = 4'hA; m1_wstrb[k] = 4'hA;
    for (int c = 1; c <= v.lat; c++) begin
      t = $sformatf("v%0d acc%0d", n, c);
      chk({t, " gnt_sel"},   32'(v.who ? m1_gnt[k] : m0_gnt[k]), 32'(c == 1));
      chk({t, " gnt_oth"},   32'(v.who ? m0_gnt[k] : m1_gnt[k]), 32'd0);
      chk({t, " done_sel"},  32'(v.who ? m1_done[k] : m0_done[k]), 32'd0);
      chk({t, " mem_read"},  32'(mem_read[k]),  32'(!v.we));
      chk({t, " mem_write"}, 32'(mem_write[k]), 32'(v.we));
      chk({t, " mem_addr"},  mem_addr[k],       v.addr);
      chk({t, " mem_wdata"}, mem_wdata[k],      v.wdata);
      chk({t, " mem_wstrb"}, 32'(mem_wstrb[k]), 32'(v.wstrb));
      tick();
    end
    t = $sformatf("v%0d done", n);
    chk({t, " done_sel"},  32'(v.who ? m1_done[k] : m0_done[k]), 32'd1);
    chk({t, " rdata_sel"}, v.who ? m1_rdata[k] : m0_rdata[k], v.exp_rdata);
    chk({t, " done_oth"},  32'(v.who ? m0_done[k] : m1_done[k]), 32'd0);
    chk({t, " rdata_oth"}, v.who ? m0_rdata[k] : m1_rdata[k], 32'd0);
    chk({t, " mem_read"},  32'(mem_read[k]),  32'd0);
    chk({t, " mem_write"}, 32'(mem_write[k]), 32'd0);
    tick();
    chk_quiet(k, $sformatf("v%0d idle", n));
  endtask

  vec_t vecs [5];
  int   gwho [4];
  int   gcyc [4];
  int   ng;
  int   wait_n;

  initial begin
    vecs[0] = '{lat:1, who:1'b0, we:1'b0, addr:32'h0000_0100, wdata:32'h0,
                wstrb:4'hF, mdata:32'hDEAD_BEEF, exp_rdata:32'hDEAD_BEEF};
    vecs[1] = '{lat:3, who:1'b1, we:1'b1, addr:32'h0000_2000, wdata:32'h1234_5678,
                wstrb:4'hF, mdata:32'h9999_9999, exp_rdata:32'h0};
    vecs[2] = '{lat:2, who:1'b0, we:1'b1, addr:32'h0000_0044, wdata:32'hAAAA_5555,
                wstrb:4'h0, mdata:32'h7777_7777, exp_rdata:32'h0};
    vecs[3] = '{lat:2, who:1'b1, we:1'b0, addr:32'h0000_0300, wdata:32'h0,
                wstrb:4'h3, mdata:32'hCAFE_F00D, exp_rdata:32'hCAFE_F00D};
    vecs[4] = '{lat:3, who:1'b0, we:1'b0, addr:32'h0000_0008, wdata:32'h0,
                wstrb:4'hC, mdata:32'h0000_00A5, exp_rdata:32'h0000_00A5};

    for (int k = 0; k < 3; k++) begin
      m0_req[k] = 1'b0; m0_we[k] = 1'b0; m0_addr[k] = '0; m0_wdata[k] = '0; m0_wstrb[k] = '0;
      m1_req[k] = 1'b0; m1_we[k] = 1'b0; m1_addr[k] = '0; m1_wdata[k] = '0; m1_wstrb[k] = '0;
      mem_rdata[k] = '0;
    end

    rst = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) chk_quiet(k, $sformatf("reset L%0d", k + 1));
    rst = 1'b0;
    tick();

    for (int n = 0; n < 5; n++) run_vec(n, vecs[n]);

    // Both requests held from reset on LAT=2: grants alternate, spaced LAT+2.
    m0_req[1] = 1'b1; m0_we[1] = 1'b0; m0_addr[1] = 32'h10;
    m1_req[1] = 1'b1; m1_we[1] = 1'b1; m1_addr[1] = 32'h20;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_quiet(1, "rr reset");
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      tick();
      if (m0_gnt[1] || m1_gnt[1]) begin
        gwho[ng] = m1_gnt[1] ? 1 : 0;
        gcyc[ng] = c;
        ng++;
      end
    end
    drop(1);
    chk("rr grant_count", 32'(ng), 32'd4);
    for (int i = 0; i < ng; i++) begin
      chk($sformatf("rr grant%0d_who", i), 32'(gwho[i]), 32'(i % 2));
      if (i > 0) chk($sformatf("rr spacing%0d", i), 32'(gcyc[i] - gcyc[i - 1]), 32'd4);
    end
    repeat (6) tick();

    // m1 asks while m0 is mid-access on LAT=3: m1 granted LAT+2 after m0.
    m0_req[2] = 1'b1; m0_we[2] = 1'b0;
    tick();
    drop(2);
    chk("late m0_gnt", 32'(m0_gnt[2]), 32'd1);
    m1_req[2] = 1'b1; m1_we[2] = 1'b1;
    wait_n = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (m1_gnt[2]) begin
        wait_n = c;
        break;
      end
    end
    m1_req[2] = 1'b0;
    chk("late m1_gnt_delay", 32'(wait_n), 32'd5);
    repeat (6) tick();

    // m0 wins (last=m0), then reset in ACCESS cycle 2: no done, tie goes to m0.
    m0_req[2] = 1'b1; m0_we[2] = 1'b0; m0_addr[2] = 32'h40;
    tick();
    drop(2);
    tick();
    chk("midrst pre mem_read", 32'(mem_read[2]), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_quiet(2, "midrst after");
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_quiet(2, $sformatf("midrst wait%0d", c));
    end
    m0_req[2] = 1'b1;
    m1_req[2] = 1'b1;
    tick();
    drop(2);
    chk("midrst tie m0_gnt", 32'(m0_gnt[2]), 32'd1);
    chk("midrst tie m1_gnt", 32'(m1_gnt[2]), 32'd0);
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
